// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: bus width, counter width and FSM encodings.
package div_unit_pkg;

  localparam int DATA_BUS_WIDTH = 32;
  localparam int DIV_CNT_WIDTH  = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Snapshot of the control state for checkers and debug visibility.
  typedef struct packed {
    div_state_e                 state;
    logic [DIV_CNT_WIDTH-1:0]   cnt;
  } div_dbg_t;

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring-division iteration on a {rem, quo} pair.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DATA_BUS_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // One extra bit: the shifted remainder can reach 2*divisor-1.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    rem_sh = {rem_i, quo_i[WIDTH-1]};
    diff   = rem_sh - {1'b0, div_i};
    quo_o  = {quo_i[WIDTH-2:0], 1'b0};
    rem_o  = rem_sh[WIDTH-1:0];
    if (rem_sh >= {1'b0, div_i}) begin
      rem_o    = diff[WIDTH-1:0];
      quo_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU (quotient on lo_out, remainder on hi_out).
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |divisor| > |dividend|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DATA_BUS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall_req,
  output logic             hilo_write_en,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output div_dbg_t         dbg_o
);

  localparam logic [DIV_CNT_WIDTH-1:0] CNT_LAST = DIV_CNT_WIDTH'(WIDTH - 1);

  div_state_e               state_q;
  logic [DIV_CNT_WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0]         rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0]         hi_q, lo_q;
  logic                     quo_neg_q, rem_neg_q;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             accept, dvs_zero, early;
  logic [WIDTH-1:0] step_rem, step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    dvd_neg  = is_signed & dividend[WIDTH-1];
    dvs_neg  = is_signed & divisor[WIDTH-1];
    dvd_mag  = dvd_neg ? -dividend : dividend;
    dvs_mag  = dvs_neg ? -divisor : divisor;
    accept   = (state_q == DIV_IDLE) && start && !flush;
    dvs_zero = (divisor == '0);
`ifdef DIV_EARLY_OUT_EN
    early    = !dvs_zero && (dvs_mag > dvd_mag);
`else
    early    = 1'b0;
`endif
  end

  // Handshake: the pipeline holds start high while stall_req is high; the
  // operation is taken on the first edge with start && !flush in IDLE, and the
  // result is presented for exactly one cycle (hilo_write_en) with stall_req low
  // so the same instruction advances. flush cancels in any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (flush) begin
      state_q <= DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            rem_q     <= '0;
            quo_q     <= dvd_mag;
            dvs_q     <= dvs_mag;
            quo_neg_q <= dvd_neg ^ dvs_neg;
            rem_neg_q <= dvd_neg;
            cnt_q     <= '0;
            if (dvs_zero) begin
              lo_q    <= '1;
              hi_q    <= dividend;
              state_q <= DIV_DONE;
            end else if (early) begin
              lo_q    <= '0;
              hi_q    <= dividend;
              state_q <= DIV_DONE;
            end else begin
              state_q <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            lo_q    <= quo_neg_q ? -step_quo : step_quo;
            hi_q    <= rem_neg_q ? -step_rem : step_rem;
            state_q <= DIV_DONE;
          end
        end
        DIV_DONE: state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

  // Gated by rst so a held start cannot raise stall_req during reset.
  assign stall_req     = rst && (accept || ((state_q == DIV_CALC) && !flush));
  assign hilo_write_en = rst && (state_q == DIV_DONE) && !flush;
  assign hi_out        = hi_q;
  assign lo_out        = lo_q;
  assign dbg_o         = '{state: state_q, cnt: cnt_q};

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, flush, async reset and random ops.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk, rst, start, is_signed, flush;
  logic [W-1:0] dividend, divisor;
  logic         stall_req, hilo_write_en;
  logic [W-1:0] hi_out, lo_out;
  div_dbg_t     dbg;

  logic [2*W-1:0] exp_q[$];
  int             n_vec, n_err;
  logic [W-1:0]   last_hi, last_lo;

  div_unit #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .is_signed     (is_signed),
    .flush         (flush),
    .dividend      (dividend),
    .divisor       (divisor),
    .stall_req     (stall_req),
    .hilo_write_en (hilo_write_en),
    .hi_out        (hi_out),
    .lo_out        (lo_out),
    .dbg_o         (dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] ma, mb, q, r;
    if (b == '0) return {a, {W{1'b1}}};
    ma = (s && a[W-1]) ? -a : a;
    mb = (s && b[W-1]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (s && (a[W-1] ^ b[W-1])) q = -q;
    if (s && a[W-1]) r = -r;
    return {r, q};
  endfunction

  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] ma, mb;
    ma = (s && a[W-1]) ? -a : a;
    mb = (s && b[W-1]) ? -b : b;
    if (b == '0) return 1;
    if (EARLY && mb > ma) return 1;
    return W + 1;
  endfunction

  // scoreboard: compare each result pulse against the oldest expectation
  always @(negedge clk) begin : monitor
    logic [2*W-1:0] e;
    if (rst && hilo_write_en) begin
      if (exp_q.size() == 0) begin
        chk("spurious_wr", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("hi", hi_out, e[2*W-1:W]);
        chk("lo", lo_out, e[W-1:0]);
      end
    end
  end

  // Called at a drive point; start stays high through DONE, caller drops it.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int lat, input logic [W-1:0] e_hi, input logic [W-1:0] e_lo);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    exp_q.push_back({e_hi, e_lo});
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      chk("stall", stall_req, (k < lat));
      chk("wr", hilo_write_en, (k == lat));
      @(posedge clk); #1;
    end
    last_hi = e_hi;
    last_lo = e_lo;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [2*W-1:0] m;
    logic [W-1:0]   a, b;
    logic           s;
    n_vec = 0; n_err = 0;
    rst = 1'b0; start = 1'b1; flush = 1'b0; is_signed = 1'b0;
    dividend = 32'd7; divisor = 32'd1;

    // reset state, with start held high
    @(negedge clk);
    chk("rst_stall", stall_req, 0);
    chk("rst_wr", hilo_write_en, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;
    idle(2);

    // directed vectors
    do_div(32'd100, 32'd7, 1'b0, 33, 32'd2, 32'd14);
    idle(1);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 33, 32'd1, 32'hFFFF_FFFD);
    idle(1);
    do_div(32'd5, 32'd0, 1'b0, 1, 32'd5, 32'hFFFF_FFFF);
    idle(1);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'd0, 32'h8000_0000);
    idle(1);
    do_div(32'd3, 32'd10, 1'b0, EARLY ? 1 : 33, 32'd3, 32'd0);
    idle(1);
    do_div(32'hFFFF_FFFD, 32'd10, 1'b1, EARLY ? 1 : 33, 32'hFFFF_FFFD, 32'd0);
    idle(1);

    // flush in cycle 10 of a CALC, no result expected
    dividend = 32'd20; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      if (k == 10) flush = 1'b1;
      if (k == 11) begin flush = 1'b0; start = 1'b0; end
      @(negedge clk);
      chk("fl_stall", stall_req, (k < 10));
      chk("fl_wr", hilo_write_en, 0);
      if (k >= 10) begin
        chk("fl_hi", hi_out, last_hi);
        chk("fl_lo", lo_out, last_lo);
      end
      @(posedge clk); #1;
    end
    do_div(32'd50, 32'd5, 1'b0, 33, 32'd0, 32'd10);
    idle(1);

    // async reset mid-CALC
    dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    chk("arst_hi", hi_out, 0);
    chk("arst_lo", lo_out, 0);
    chk("arst_stall", stall_req, 0);
    chk("arst_wr", hilo_write_en, 0);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;
    idle(1);
    do_div(32'd9, 32'd3, 1'b0, 33, 32'd0, 32'd3);

    // random back-to-back operations
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(1, 20);
        1:       b = -$urandom_range(1, 20);
        2:       b = (i == 6) ? 32'd0 : $urandom;
        default: b = $urandom;
      endcase
      s = $urandom_range(0, 1);
      m = model(a, b, s);
      do_div(a, b, s, model_lat(a, b, s), m[2*W-1:W], m[W-1:0]);
    end
    idle(3);
    chk("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
